vga_timing_gen: RTL and testbench

- Parametrised successor to the fixed 640x480@60 VGA driver.
- Generates HS/VS/DE timing for any resolution from parameters, with programmable sync polarity.
- Issues pixel-coordinate requests a configurable number of cycles ahead of display, to match the pixel pipeline latency of the game core.
- Adds coordinate down-scaling, run enable, line/frame strobes and a frame counter. Sits between CORE_Gm and the VGA port.

---
 rtl/vga_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen
//   Parametrised VGA timing generator. Produces HS/VS/DE from free-running
//   H/V counters, issues pixel-coordinate requests REQ_LEAD clocks ahead of
//   display so a pipelined pixel source lines up with DE, and provides
//   line/frame strobes plus a completed-frame counter.
//
// Ports:
//   VGA_clk          pixel clock
//   VGA_rst          asynchronous reset, active-high
//   VGA_Enable       run enable; low holds the counters at the top of frame
//   VGA_PixelSignal  pixel returned by the core for an earlier request
//   VGA_HS / VGA_VS  sync outputs, active level HS_POL / VS_POL
//   VGA_DE           display-enable window
//   VGA_PortSignal   RGB to the port, zero outside DE
//   VGA_DataReq      coordinate request valid
//   VGA_CurCoorX/Y   requested coordinates (scaled), zero when no request
//   VGA_LineStart    strobe at cnt_h = 0
//   VGA_FrameStart   strobe at cnt_h = 0, cnt_v = 0
//   VGA_FrameCnt     completed-frame counter, wraps
module vga_timing_gen #(
    parameter int unsigned PIX_W       = 16,
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned H_DISP      = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned V_DISP      = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned REQ_LEAD    = 1,
    parameter int unsigned SCALE_SHIFT = 0
) (
    input  logic             VGA_clk,
    input  logic             VGA_rst,
    input  logic             VGA_Enable,
    input  logic [PIX_W-1:0] VGA_PixelSignal,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic             VGA_DE,
    output logic [PIX_W-1:0] VGA_PortSignal,
    output logic             VGA_DataReq,
    output logic [CNT_W-1:0] VGA_CurCoorX,
    output logic [CNT_W-1:0] VGA_CurCoorY,
    output logic             VGA_LineStart,
    output logic             VGA_FrameStart,
    output logic [7:0]       VGA_FrameCnt
);

    localparam int unsigned H_TOTAL     = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL     = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned HA          = H_SYNC + H_BACK;
    localparam int unsigned VA          = V_SYNC + V_BACK;
    // First column of the request window: requests run REQ_LEAD clocks ahead of DE.
    localparam int unsigned H_REQ_START = HA - REQ_LEAD;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_REQ_OFS = CNT_W'(H_REQ_START);
    localparam logic [CNT_W-1:0] V_ACT_OFS = CNT_W'(VA);

    if ((REQ_LEAD == 0) || (REQ_LEAD > HA)) begin : gen_bad_lead
        $error("vga_timing_gen: REQ_LEAD must be in 1..H_SYNC+H_BACK");
    end
    if ((H_TOTAL >= (32'd1 << CNT_W)) || (V_TOTAL >= (32'd1 << CNT_W))) begin : gen_bad_width
        $error("vga_timing_gen: H/V totals do not fit in CNT_W");
    end

    logic [CNT_W-1:0] cntH_r;
    logic [CNT_W-1:0] cntV_r;
    logic [7:0]       frameCnt_r;

    logic [31:0]      hPos_s;
    logic [31:0]      vPos_s;
    logic             hEnd_s;
    logic             vEnd_s;
    logic             hSync_s;
    logic             vSync_s;
    logic             hDisp_s;
    logic             vDisp_s;
    logic             hReq_s;
    logic             de_s;
    logic             req_s;
    logic [CNT_W-1:0] rawX_s;
    logic [CNT_W-1:0] rawY_s;

    // Position decode: all window tests are done on zero-extended counters so
    // end-of-window bounds equal to the total cannot overflow CNT_W.
    always_comb begin
        hPos_s  = 32'(cntH_r);
        vPos_s  = 32'(cntV_r);
        hEnd_s  = (hPos_s == (H_TOTAL - 32'd1));
        vEnd_s  = (vPos_s == (V_TOTAL - 32'd1));
        hSync_s = (hPos_s < H_SYNC);
        vSync_s = (vPos_s < V_SYNC);
        hDisp_s = (hPos_s >= HA) && (hPos_s < (HA + H_DISP));
        vDisp_s = (vPos_s >= VA) && (vPos_s < (VA + V_DISP));
        hReq_s  = (hPos_s >= H_REQ_START) && (hPos_s < (H_REQ_START + H_DISP));
        de_s    = hDisp_s && vDisp_s;
        req_s   = hReq_s && vDisp_s;
        rawX_s  = cntH_r - H_REQ_OFS;
        rawY_s  = cntV_r - V_ACT_OFS;
    end

    // H/V counters: disable parks them at the top of frame.
    always_ff @(posedge VGA_clk or posedge VGA_rst) begin
        if (VGA_rst) begin
            cntH_r <= CNT_ZERO;
            cntV_r <= CNT_ZERO;
        end else if (!VGA_Enable) begin
            cntH_r <= CNT_ZERO;
            cntV_r <= CNT_ZERO;
        end else if (hEnd_s) begin
            cntH_r <= CNT_ZERO;
            if (vEnd_s) begin
                cntV_r <= CNT_ZERO;
            end else begin
                cntV_r <= cntV_r + CNT_ONE;
            end
        end else begin
            cntH_r <= cntH_r + CNT_ONE;
            cntV_r <= cntV_r;
        end
    end

    // Completed-frame counter: holds while disabled, wraps naturally at 8 bits.
    always_ff @(posedge VGA_clk or posedge VGA_rst) begin
        if (VGA_rst) begin
            frameCnt_r <= 8'd0;
        end else if (VGA_Enable && hEnd_s && vEnd_s) begin
            frameCnt_r <= frameCnt_r + 8'd1;
        end else begin
            frameCnt_r <= frameCnt_r;
        end
    end

    // Output decode: combinational from the counters so there is no added latency.
    always_comb begin
        VGA_HS         = ~HS_POL;
        VGA_VS         = ~VS_POL;
        VGA_DE         = de_s;
        VGA_PortSignal = {PIX_W{1'b0}};
        VGA_DataReq    = req_s;
        VGA_CurCoorX   = CNT_ZERO;
        VGA_CurCoorY   = CNT_ZERO;
        VGA_LineStart  = VGA_Enable && (cntH_r == CNT_ZERO);
        VGA_FrameStart = VGA_Enable && (cntH_r == CNT_ZERO) && (cntV_r == CNT_ZERO);
        VGA_FrameCnt   = frameCnt_r;
        if (hSync_s) begin
            VGA_HS = HS_POL;
        end else begin
            VGA_HS = ~HS_POL;
        end
        if (vSync_s) begin
            VGA_VS = VS_POL;
        end else begin
            VGA_VS = ~VS_POL;
        end
        if (de_s) begin
            VGA_PortSignal = VGA_PixelSignal;
        end else begin
            VGA_PortSignal = {PIX_W{1'b0}};
        end
        if (req_s) begin
            VGA_CurCoorX = rawX_s >> SCALE_SHIFT;
            VGA_CurCoorY = rawY_s >> SCALE_SHIFT;
        end else begin
            VGA_CurCoorX = CNT_ZERO;
            VGA_CurCoorY = CNT_ZERO;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Directed bench for vga_timing_gen: four instances (defaults, REQ_LEAD=3 with
// inverted sync and a 3-cycle core model, SCALE_SHIFT=1 with a short frame,
// and a tiny raster for frame length, reset and enable behaviour).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en, rstS, enS;
    logic [15:0] pixDef, pixScale, pixSmall;
    logic [19:0] pixLead;

    logic dHs, dVs, dDe, dReq, dLs, dFs;
    logic [15:0] dPort;
    logic [9:0] dX, dY;
    logic [7:0] dFc;

    logic lHs, lVs, lDe, lReq, lLs, lFs;
    logic [19:0] lPort;
    logic [9:0] lX, lY;
    logic [7:0] lFc;

    logic sHs, sVs, sDe, sReq, sLs, sFs;
    logic [15:0] sPort;
    logic [9:0] sX, sY;
    logic [7:0] sFc;

    logic mHs, mVs, mDe, mReq, mLs, mFs;
    logic [15:0] mPort;
    logic [9:0] mX, mY;
    logic [7:0] mFc;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    int cycS    = 0;

    vga_timing_gen u_def (
        .VGA_clk(clk), .VGA_rst(rst), .VGA_Enable(en), .VGA_PixelSignal(pixDef),
        .VGA_HS(dHs), .VGA_VS(dVs), .VGA_DE(dDe), .VGA_PortSignal(dPort),
        .VGA_DataReq(dReq), .VGA_CurCoorX(dX), .VGA_CurCoorY(dY),
        .VGA_LineStart(dLs), .VGA_FrameStart(dFs), .VGA_FrameCnt(dFc));

    vga_timing_gen #(.PIX_W(20), .REQ_LEAD(3), .HS_POL(1'b1), .VS_POL(1'b1)) u_lead (
        .VGA_clk(clk), .VGA_rst(rst), .VGA_Enable(en), .VGA_PixelSignal(pixLead),
        .VGA_HS(lHs), .VGA_VS(lVs), .VGA_DE(lDe), .VGA_PortSignal(lPort),
        .VGA_DataReq(lReq), .VGA_CurCoorX(lX), .VGA_CurCoorY(lY),
        .VGA_LineStart(lLs), .VGA_FrameStart(lFs), .VGA_FrameCnt(lFc));

    vga_timing_gen #(.V_SYNC(2), .V_BACK(3), .V_DISP(8), .V_FRONT(1), .SCALE_SHIFT(1)) u_scale (
        .VGA_clk(clk), .VGA_rst(rst), .VGA_Enable(en), .VGA_PixelSignal(pixScale),
        .VGA_HS(sHs), .VGA_VS(sVs), .VGA_DE(sDe), .VGA_PortSignal(sPort),
        .VGA_DataReq(sReq), .VGA_CurCoorX(sX), .VGA_CurCoorY(sY),
        .VGA_LineStart(sLs), .VGA_FrameStart(sFs), .VGA_FrameCnt(sFc));

    vga_timing_gen #(.H_SYNC(4), .H_BACK(2), .H_DISP(8), .H_FRONT(2),
                     .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1)) u_small (
        .VGA_clk(clk), .VGA_rst(rstS), .VGA_Enable(enS), .VGA_PixelSignal(pixSmall),
        .VGA_HS(mHs), .VGA_VS(mVs), .VGA_DE(mDe), .VGA_PortSignal(mPort),
        .VGA_DataReq(mReq), .VGA_CurCoorX(mX), .VGA_CurCoorY(mY),
        .VGA_LineStart(mLs), .VGA_FrameStart(mFs), .VGA_FrameCnt(mFc));

    // Core model: returns {X,Y} three clocks after the request.
    logic [2:0][19:0] leadPipe;
    always @(posedge clk) begin
        leadPipe[0] <= lReq ? {lX, lY} : 20'h0;
        leadPipe[1] <= leadPipe[0];
        leadPipe[2] <= leadPipe[1];
    end
    assign pixLead = leadPipe[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to big-raster clock count t (sampled on the falling edge).
    task automatic goBig(input int t);
        repeat (t - cyc) @(negedge clk);
        cycS += t - cyc;
        cyc = t;
    endtask

    // Advance to small-raster clock count t.
    task automatic goSmall(input int t);
        repeat (t - cycS) @(negedge clk);
        cyc += t - cycS;
        cycS = t;
    endtask

    initial begin
        rst = 1'b1; rstS = 1'b1; en = 1'b1; enS = 1'b1;
        pixDef = 16'hA5C3; pixScale = 16'h1234; pixSmall = 16'h00FF;
        repeat (4) @(negedge clk);

        check("rst_hs", 32'(dHs), 32'd0);
        check("rst_vs", 32'(dVs), 32'd0);
        check("rst_de", 32'(dDe), 32'd0);
        check("rst_req", 32'(dReq), 32'd0);
        check("rst_x", 32'(dX), 32'd0);
        check("rst_y", 32'(dY), 32'd0);
        check("rst_port", 32'(dPort), 32'd0);
        check("rst_ls", 32'(dLs), 32'd1);
        check("rst_fs", 32'(dFs), 32'd1);
        check("rst_fc", 32'(dFc), 32'd0);
        check("rst_pol_hs", 32'(lHs), 32'd1);
        check("rst_pol_vs", 32'(lVs), 32'd1);

        rst = 1'b0;
        cyc = 0;
        check("c0_ls", 32'(dLs), 32'd1);
        check("c0_fs", 32'(dFs), 32'd1);
        check("c0_hs", 32'(dHs), 32'd0);
        check("c0_pol_hs", 32'(lHs), 32'd1);
        goBig(1);
        check("c1_ls", 32'(dLs), 32'd0);
        check("c1_fs", 32'(dFs), 32'd0);
        goBig(95);
        check("h95_hs", 32'(dHs), 32'd0);
        check("h95_pol_hs", 32'(lHs), 32'd1);
        goBig(96);
        check("h96_hs", 32'(dHs), 32'd1);
        check("h96_pol_hs", 32'(lHs), 32'd0);
        goBig(143);
        check("v0_req", 32'(dReq), 32'd0);
        check("v0_de", 32'(dDe), 32'd0);
        goBig(800);
        check("v1_vs", 32'(dVs), 32'd0);
        check("v1_ls", 32'(dLs), 32'd1);
        check("v1_fs", 32'(dFs), 32'd0);
        check("v1_pol_vs", 32'(lVs), 32'd1);
        goBig(1600);
        check("v2_vs", 32'(dVs), 32'd1);
        check("v2_pol_vs", 32'(lVs), 32'd0);

        // Scaled instance: active rows 5..12.
        goBig(4143);
        check("sc_req", 32'(sReq), 32'd1);
        check("sc_x0", 32'(sX), 32'd0);
        check("sc_y0", 32'(sY), 32'd0);
        goBig(4144);
        check("sc_x1", 32'(sX), 32'd0);
        goBig(4145);
        check("sc_x2", 32'(sX), 32'd1);
        goBig(4146);
        check("sc_x3", 32'(sX), 32'd1);
        goBig(4943);
        check("sc_row6_y", 32'(sY), 32'd0);
        goBig(5743);
        check("sc_row7_y", 32'(sY), 32'd1);
        goBig(9743);
        check("sc_last_y", 32'(sY), 32'd3);
        goBig(10382);
        check("sc_last_x", 32'(sX), 32'd319);
        goBig(10543);
        check("sc_front_req", 32'(sReq), 32'd0);
        check("sc_front_y", 32'(sY), 32'd0);

        goBig(27344);
        check("v34_de", 32'(dDe), 32'd0);
        check("v34_req", 32'(dReq), 32'd0);

        // Row 35: first active row.
        goBig(28140);
        check("ld_h140_req", 32'(lReq), 32'd0);
        goBig(28141);
        check("ld_h141_req", 32'(lReq), 32'd1);
        check("ld_h141_x", 32'(lX), 32'd0);
        check("ld_h141_y", 32'(lY), 32'd0);
        goBig(28142);
        check("h142_req", 32'(dReq), 32'd0);
        goBig(28143);
        check("h143_req", 32'(dReq), 32'd1);
        check("h143_x", 32'(dX), 32'd0);
        check("h143_y", 32'(dY), 32'd0);
        check("h143_de", 32'(dDe), 32'd0);
        check("h143_port", 32'(dPort), 32'd0);
        goBig(28144);
        check("h144_de", 32'(dDe), 32'd1);
        check("h144_port", 32'(dPort), 32'hA5C3);
        check("h144_x", 32'(dX), 32'd1);
        check("ld_h144_de", 32'(lDe), 32'd1);
        check("ld_h144_port", 32'(lPort), 32'h00000);
        goBig(28145);
        check("ld_h145_port", 32'(lPort), 32'h00400);
        goBig(28780);
        check("ld_h780_req", 32'(lReq), 32'd1);
        check("ld_h780_x", 32'(lX), 32'd639);
        goBig(28781);
        check("ld_h781_req", 32'(lReq), 32'd0);
        check("ld_h781_x", 32'(lX), 32'd0);
        goBig(28782);
        check("h782_x", 32'(dX), 32'd639);
        check("h782_y", 32'(dY), 32'd0);
        check("h782_req", 32'(dReq), 32'd1);
        goBig(28783);
        check("h783_req", 32'(dReq), 32'd0);
        check("h783_x", 32'(dX), 32'd0);
        check("h783_de", 32'(dDe), 32'd1);
        check("h783_port", 32'(dPort), 32'hA5C3);
        check("ld_h783_port", 32'(lPort), 32'h9FC00);
        check("ld_h783_de", 32'(lDe), 32'd1);
        goBig(28784);
        check("h784_de", 32'(dDe), 32'd0);
        check("h784_port", 32'(dPort), 32'd0);
        check("ld_h784_port", 32'(lPort), 32'd0);
        goBig(28944);
        check("ld_r36_first", 32'(lPort), 32'h00001);
        goBig(29583);
        check("ld_r36_last", 32'(lPort), 32'h9FC01);

        // Small raster: 16 x 7 = 112 clocks per frame.
        rstS = 1'b0;
        cycS = 0;
        check("sm_c0_ls", 32'(mLs), 32'd1);
        check("sm_c0_fs", 32'(mFs), 32'd1);
        check("sm_c0_fc", 32'(mFc), 32'd0);
        goSmall(6);
        check("sm_v0_de", 32'(mDe), 32'd0);
        goSmall(37);
        check("sm_req", 32'(mReq), 32'd1);
        check("sm_req_x", 32'(mX), 32'd0);
        check("sm_req_y", 32'(mY), 32'd0);
        check("sm_req_de", 32'(mDe), 32'd0);
        goSmall(38);
        check("sm_de", 32'(mDe), 32'd1);
        check("sm_port", 32'(mPort), 32'h00FF);
        goSmall(111);
        check("sm_c111_fs", 32'(mFs), 32'd0);
        check("sm_c111_fc", 32'(mFc), 32'd0);
        goSmall(112);
        check("sm_c112_fs", 32'(mFs), 32'd1);
        check("sm_c112_fc", 32'(mFc), 32'd1);
        goSmall(224);
        check("sm_c224_fc", 32'(mFc), 32'd2);
        check("sm_c224_fs", 32'(mFs), 32'd1);
        goSmall(247);
        check("sm_h7_hs", 32'(mHs), 32'd1);
        check("sm_h7_vs", 32'(mVs), 32'd1);
        check("sm_h7_ls", 32'(mLs), 32'd0);

        // Mid-line reset must clear without waiting for a clock edge.
        rstS = 1'b1;
        #1;
        check("sm_arst_hs", 32'(mHs), 32'd0);
        check("sm_arst_vs", 32'(mVs), 32'd0);
        check("sm_arst_ls", 32'(mLs), 32'd1);
        check("sm_arst_fs", 32'(mFs), 32'd1);
        check("sm_arst_fc", 32'(mFc), 32'd0);
        rstS = 1'b0;
        cycS = 0;
        goSmall(128);
        check("sm_l1_ls", 32'(mLs), 32'd1);
        check("sm_l1_fs", 32'(mFs), 32'd0);
        check("sm_l1_fc", 32'(mFc), 32'd1);

        enS = 1'b0;
        #1;
        check("sm_dis_ls", 32'(mLs), 32'd0);
        check("sm_dis_fs", 32'(mFs), 32'd0);
        goSmall(133);
        check("sm_dis5_fs", 32'(mFs), 32'd0);
        check("sm_dis5_fc", 32'(mFc), 32'd1);
        check("sm_dis5_hs", 32'(mHs), 32'd0);
        enS = 1'b1;
        #1;
        check("sm_ren_fs", 32'(mFs), 32'd1);
        check("sm_ren_ls", 32'(mLs), 32'd1);
        check("sm_ren_fc", 32'(mFc), 32'd1);
        cycS = 0;
        goSmall(1);
        check("sm_ren1_fs", 32'(mFs), 32'd0);
        goSmall(112);
        check("sm_ren_frame_fs", 32'(mFs), 32'd1);
        check("sm_ren_frame_fc", 32'(mFc), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
